// File: rtl/traffic_light_fsm.sv
// Two-road signal controller: the main road rests in green until side-road or pedestrian demand.
// Define PED_WALK_EN to latch pedestrian requests and drive the walk lamp during the side-road green.
module traffic_light_fsm #(
    parameter int NS_GREEN_MIN  = 10,
    parameter int YELLOW_TIME   = 3,
    parameter int ALLRED_TIME   = 1,
    parameter int EW_GREEN_TIME = 8
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick,
    input  logic       car_ew,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [2:0] state,
    output logic [7:0] sec_left
);
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_A  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_B  = 3'd5
    } state_e;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam logic [7:0] NS_GREEN_LOAD = 8'(NS_GREEN_MIN - 1);
    localparam logic [7:0] YELLOW_LOAD   = 8'(YELLOW_TIME - 1);
    localparam logic [7:0] ALLRED_LOAD   = 8'(ALLRED_TIME - 1);
    localparam logic [7:0] EW_GREEN_LOAD = 8'(EW_GREEN_TIME - 1);

    function automatic logic [7:0] load_value(input state_e s);
        case (s)
            NS_YELLOW, EW_YELLOW: return YELLOW_LOAD;
            ALLRED_A, ALLRED_B:   return ALLRED_LOAD;
            EW_GREEN:             return EW_GREEN_LOAD;
            default:              return NS_GREEN_LOAD;
        endcase
    endfunction

    // Illegal codes fall through to NS_GREEN, which also closes the ring after ALLRED_B.
    function automatic state_e successor(input state_e s);
        case (s)
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return ALLRED_A;
            ALLRED_A:  return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            EW_YELLOW: return ALLRED_B;
            default:   return NS_GREEN;
        endcase
    endfunction

    function automatic logic [2:0] ns_lamp(input state_e s);
        case (s)
            NS_GREEN:  return LAMP_G;
            NS_YELLOW: return LAMP_Y;
            default:   return LAMP_R;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input state_e s);
        case (s)
            EW_GREEN:  return LAMP_G;
            EW_YELLOW: return LAMP_Y;
            default:   return LAMP_R;
        endcase
    endfunction

    state_e     state_q, state_d;
    logic [7:0] sec_left_q, sec_left_d;
    logic [2:0] ns_light_q, ns_light_d;
    logic [2:0] ew_light_q, ew_light_d;
    logic       walk_q, walk_d;
    logic       ped_pending;
    logic       expired;
    logic       advance;
    logic       enter_ew;

    always_comb begin
        state_d    = state_q;
        sec_left_d = sec_left_q;
        advance    = 1'b0;
        expired    = tick && (sec_left_q == 8'd0);
        case (state_q)
            NS_GREEN:                                          advance = expired && (car_ew || ped_pending);
            NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B: advance = expired;
            default:                                           advance = 1'b1;
        endcase
        if (advance) begin
            state_d    = successor(state_q);
            sec_left_d = load_value(state_d);
        end else if (tick && (sec_left_q != 8'd0)) begin
            sec_left_d = sec_left_q - 8'd1;
        end
        enter_ew   = (state_d == EW_GREEN) && (state_q != EW_GREEN);
        // Walk is decided once, at green entry, from the request latched before that edge.
        walk_d     = (state_d == EW_GREEN) ? (enter_ew ? ped_pending : walk_q) : 1'b0;
        ns_light_d = ns_lamp(state_d);
        ew_light_d = ew_lamp(state_d);
    end

`ifdef PED_WALK_EN
    logic ped_pending_q, ped_pending_d;
    // Entering the side-road green serves the request, so the clear beats a simultaneous press.
    always_comb ped_pending_d = enter_ew ? 1'b0 : (ped_pending_q | ped_req);
    assign ped_pending = ped_pending_q;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
    assign ped_pending    = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q       <= NS_GREEN;
            sec_left_q    <= NS_GREEN_LOAD;
            ns_light_q    <= LAMP_G;
            ew_light_q    <= LAMP_R;
            walk_q        <= 1'b0;
`ifdef PED_WALK_EN
            ped_pending_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sec_left_q    <= sec_left_d;
            ns_light_q    <= ns_light_d;
            ew_light_q    <= ew_light_d;
            walk_q        <= walk_d;
`ifdef PED_WALK_EN
            ped_pending_q <= ped_pending_d;
`endif
        end
    end

    assign state    = state_q;
    assign sec_left = sec_left_q;
    assign ns_light = ns_light_q;
    assign ew_light = ew_light_q;
    assign walk     = walk_q;
endmodule

// File: tb/tb_traffic_light_fsm.sv
// Randomised bench for traffic_light_fsm against a phase/elapsed-time model of the signal plan.
// Pedestrian scenarios are selected by PED_WALK_EN to match the build of the design.
module tb_traffic_light_fsm;
    localparam int NSG = 4, YEL = 2, ALR = 1, EWG = 3, TICK_DIV = 5;
`ifdef PED_WALK_EN
    localparam bit PED_ON = 1'b1;
`else
    localparam bit PED_ON = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0, car_ew = 1'b0, ped_req = 1'b0;
    logic [2:0] ns_light, ew_light, state;
    logic       walk;
    logic [7:0] sec_left;

    traffic_light_fsm #(
        .NS_GREEN_MIN(NSG), .YELLOW_TIME(YEL), .ALLRED_TIME(ALR), .EW_GREEN_TIME(EWG)
    ) dut (
        .clk_in(clk_in), .reset(reset), .tick(tick), .car_ew(car_ew), .ped_req(ped_req),
        .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .state(state), .sec_left(sec_left)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0, n_err = 0, cyc = 0, tick_cnt = 0;
    int ticks_in[8];
    int dur[6] = '{NSG, YEL, ALR, EWG, YEL, ALR};

    // Reference: which phase of the plan we are in and how many ticks of it have elapsed.
    int m_phase = 0, m_elapsed = 0;
    bit m_pend = 1'b0, m_walk = 1'b0;

    function automatic void model_reset();
        m_phase = 0; m_elapsed = 0; m_pend = 1'b0; m_walk = 1'b0;
    endfunction

    function automatic void model_edge(input bit tk, input bit car, input bit ped);
        bit enter_ew = 1'b0;
        if (tk) begin
            if (m_elapsed < dur[m_phase] - 1) m_elapsed++;
            else if (m_phase != 0 || car || m_pend) begin
                m_phase  = (m_phase + 1) % 6;
                m_elapsed = 0;
                enter_ew = (m_phase == 3);
            end
        end
        if (PED_ON) begin
            if (m_phase != 3) m_walk = 1'b0;
            else if (enter_ew) m_walk = m_pend;
            if (enter_ew) m_pend = 1'b0;
            else if (ped) m_pend = 1'b1;
        end
    endfunction

    function automatic logic [2:0] exp_ns();
        return (m_phase == 0) ? 3'b001 : (m_phase == 1) ? 3'b010 : 3'b100;
    endfunction
    function automatic logic [2:0] exp_ew();
        return (m_phase == 3) ? 3'b001 : (m_phase == 4) ? 3'b010 : 3'b100;
    endfunction
    function automatic logic [17:0] exp_vec();
        return {3'(m_phase), 8'(dur[m_phase] - 1 - m_elapsed), exp_ns(), exp_ew(), m_walk};
    endfunction
    function automatic logic [17:0] dut_vec();
        return {state, sec_left, ns_light, ew_light, walk};
    endfunction
    function automatic string fmt(input logic [17:0] v);
        return $sformatf("st=%0d sl=%0d ns=%b ew=%b walk=%b", v[17:15], v[14:7], v[6:4], v[3:1], v[0]);
    endfunction

    // One clk_in cycle with the given levels; called and returning at posedge+1.
    task automatic cycle(input bit car, input bit ped);
        bit tk;
        logic [2:0] prev;
        tk = (cyc % TICK_DIV) == TICK_DIV - 1;
        tick = tk; car_ew = car; ped_req = ped;
        prev = state;
        @(posedge clk_in);
        model_edge(tk, car, ped);
        if (tk) begin tick_cnt++; ticks_in[prev]++; end
        cyc++;
        #1;
        tick = 1'b0; ped_req = 1'b0;
        if (state !== prev)
            $display("cyc %0d: state %0d -> %0d sec_left=%0d walk=%b", cyc, prev, state, sec_left, walk);
    endtask

    task automatic assert_reset();
        reset = 1'b0; tick = 1'b0; ped_req = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        repeat (2) begin @(posedge clk_in); cyc++; end
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk_in); cyc++;
        #1;
        assert_reset();
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL reset_async got %s expected %s", fmt(dut_vec()), fmt(exp_vec()));
        end
        tick = 1'b1; car_ew = 1'b1;
        release_reset();
        tick = 1'b0;
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_err++; $display("FAIL reset_hold got %s expected %s", fmt(dut_vec()), fmt(exp_vec()));
        end
    endtask

    task automatic test_idle();
        assert_reset(); release_reset();
        for (int i = 0; i < 20 * TICK_DIV; i++) begin
            cycle(1'b0, 1'b0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL idle cyc=%0d got %s expected %s", cyc, fmt(dut_vec()), fmt(exp_vec()));
            end
        end
        n_cmp++;
        if (state !== 3'd0 || sec_left !== 8'd0 || ns_light !== 3'b001) begin
            n_err++; $display("FAIL idle_final got st=%0d sl=%0d ns=%b expected st=0 sl=0 ns=001", state, sec_left, ns_light);
        end
    endtask

    task automatic test_full_cycle();
        int want[6] = '{4, 2, 1, 3, 2, 1};
        bit seen_last = 1'b0;
        int guard = 0;
        assert_reset(); release_reset();
        for (int i = 0; i < 8; i++) ticks_in[i] = 0;
        while (!(seen_last && state == 3'd0) && guard < 400) begin
            cycle(1'b1, 1'b0);
            guard++;
            if (state == 3'd5) seen_last = 1'b1;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL full_cycle cyc=%0d got %s expected %s", cyc, fmt(dut_vec()), fmt(exp_vec()));
            end
            n_cmp++;
            if (ns_light !== 3'b100 && ew_light !== 3'b100) begin
                n_err++; $display("FAIL exclusive cyc=%0d got ns=%b ew=%b expected one road red", cyc, ns_light, ew_light);
            end
        end
        n_cmp++;
        if (guard >= 400) begin n_err++; $display("FAIL full_cycle_timeout got %0d cycles expected ring closure", guard); end
        for (int s = 0; s < 6; s++) begin
            n_cmp++;
            if (ticks_in[s] != want[s]) begin
                n_err++; $display("FAIL phase_len state=%0d got %0d ticks expected %0d", s, ticks_in[s], want[s]);
            end
        end
    endtask

    task automatic test_reset_mid_yellow();
        int guard = 0, t0;
        logic [2:0] s0;
        assert_reset(); release_reset();
        while (!(state == 3'd1 && sec_left == 8'd1) && guard < 200) begin
            cycle(1'b1, 1'b0); guard++;
        end
        n_cmp++;
        if (guard >= 200) begin n_err++; $display("FAIL mid_yellow_timeout got st=%0d expected st=1", state); end
        assert_reset();
        n_cmp++;
        if (state !== 3'd0 || sec_left !== 8'd3 || ns_light !== 3'b001 || ew_light !== 3'b100) begin
            n_err++; $display("FAIL mid_yellow_reset got st=%0d sl=%0d ns=%b ew=%b expected st=0 sl=3 ns=001 ew=100",
                              state, sec_left, ns_light, ew_light);
        end
        release_reset();
        t0 = tick_cnt; s0 = state; guard = 0;
        while (state === s0 && guard < 200) begin
            cycle(1'b1, 1'b0); guard++;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL post_reset cyc=%0d got %s expected %s", cyc, fmt(dut_vec()), fmt(exp_vec()));
            end
        end
        n_cmp++;
        if (tick_cnt - t0 != NSG) begin
            n_err++; $display("FAIL post_reset_ticks got %0d expected %0d", tick_cnt - t0, NSG);
        end
    endtask

    task automatic test_random();
        bit car = 1'b0;
        assert_reset(); release_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) car = ~car;
            cycle(car, $urandom_range(0, 19) == 0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL random cyc=%0d got %s expected %s", cyc, fmt(dut_vec()), fmt(exp_vec()));
            end
            n_cmp++;
            if (ns_light !== 3'b100 && ew_light !== 3'b100) begin
                n_err++; $display("FAIL exclusive cyc=%0d got ns=%b ew=%b expected one road red", cyc, ns_light, ew_light);
            end
        end
    endtask

`ifdef PED_WALK_EN
    task automatic test_ped_walk();
        int t0, walk_ticks = 0, guard = 0;
        bit left_ns = 1'b0, pressed = 1'b0;
        assert_reset(); release_reset();
        t0 = tick_cnt;
        while (!(left_ns && state == 3'd0) && guard < 400) begin
            if ((cyc % TICK_DIV) == TICK_DIV - 1 && walk === 1'b1) walk_ticks++;
            cycle(1'b0, !pressed && (tick_cnt - t0 == 1));
            if (tick_cnt - t0 == 1) pressed = 1'b1;
            if (state != 3'd0) left_ns = 1'b1;
            guard++;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL ped_walk cyc=%0d got %s expected %s", cyc, fmt(dut_vec()), fmt(exp_vec()));
            end
        end
        n_cmp++;
        if (walk_ticks != EWG) begin n_err++; $display("FAIL walk_ticks got %0d expected %0d", walk_ticks, EWG); end
        for (int i = 0; i < 10 * TICK_DIV; i++) cycle(1'b0, 1'b0);
        n_cmp++;
        if (state !== 3'd0) begin n_err++; $display("FAIL ped_cleared got st=%0d expected st=0", state); end
    endtask

    task automatic test_ped_same_edge();
        int guard = 0;
        assert_reset(); release_reset();
        while (!(state == 3'd2 && sec_left == 8'd0 && (cyc % TICK_DIV) == TICK_DIV - 1) && guard < 300) begin
            cycle(1'b1, 1'b0); guard++;
        end
        cycle(1'b1, 1'b1);
        n_cmp++;
        if (state !== 3'd3 || walk !== 1'b0) begin
            n_err++; $display("FAIL same_edge_entry got st=%0d walk=%b expected st=3 walk=0", state, walk);
        end
        for (int i = 0; i < 25 * TICK_DIV; i++) begin
            cycle(1'b0, 1'b0);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_err++; $display("FAIL same_edge cyc=%0d got %s expected %s", cyc, fmt(dut_vec()), fmt(exp_vec()));
            end
        end
        n_cmp++;
        if (state !== 3'd0) begin n_err++; $display("FAIL same_edge_no_rerun got st=%0d expected st=0", state); end
    endtask
`else
    task automatic test_ped_ignored();
        assert_reset(); release_reset();
        for (int i = 0; i < 30 * TICK_DIV; i++) begin
            cycle(1'b0, (i % 3) == 0);
            n_cmp++;
            if (state !== 3'd0 || walk !== 1'b0) begin
                n_err++; $display("FAIL ped_ignored cyc=%0d got st=%0d walk=%b expected st=0 walk=0", cyc, state, walk);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_full_cycle();
        test_reset_mid_yellow();
`ifdef PED_WALK_EN
        test_ped_walk();
        test_ped_same_edge();
`else
        test_ped_ignored();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/traffic_light_fsm.md
TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 Parameter NS_GREEN_MIN, default 10: minimum north-south (main road) green, in ticks, range 1..255.
REQ-002 Parameter YELLOW_TIME, default 3: yellow duration for either road, in ticks, range 1..255.
REQ-003 Parameter ALLRED_TIME, default 1: all-red clearance duration, in ticks, range 1..255.
REQ-004 Parameter EW_GREEN_TIME, default 8: fixed east-west (side road) green, in ticks, range 1..255.
REQ-005 clk_in  input  1  system clock (50 MHz); the only clock.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 tick  input  1  one-clk_in-cycle pulse at 1 Hz, generated synchronously in the clk_in domain; it is sampled as an enable and never used as a clock.
REQ-008 car_ew  input  1  side-road vehicle sensor, level, synchronous to clk_in.
REQ-009 ped_req  input  1  pedestrian button, single-cycle pulse, synchronous to clk_in.
REQ-010 ns_light  output  3  main-road lamps {red, yellow, green}, one-hot.
REQ-011 ew_light  output  3  side-road lamps {red, yellow, green}, one-hot.
REQ-012 walk  output  1  pedestrian walk lamp for crossing the main road.
REQ-013 state  output  3  current state encoding, per REQ-015.
REQ-014 sec_left  output  8  ticks remaining in the current state, minus one.

Function
REQ-015 The FSM SHALL use these states: NS_GREEN=0, NS_YELLOW=1, ALLRED_A=2, EW_GREEN=3, EW_YELLOW=4, ALLRED_B=5; codes 6 and 7 are illegal and SHALL go to NS_GREEN on the next clk_in edge.
REQ-016 On entry to any state, sec_left SHALL load that state's duration minus 1; NS_GREEN uses NS_GREEN_MIN.
REQ-017 On a clk_in edge with tick=1 and sec_left>0, sec_left SHALL decrement by 1; with tick=0 it SHALL hold.
REQ-018 On a clk_in edge with tick=1 and sec_left=0, the FSM SHALL advance NS_YELLOW->ALLRED_A->EW_GREEN->EW_YELLOW->ALLRED_B->NS_GREEN unconditionally.
REQ-019 NS_GREEN SHALL advance to NS_YELLOW only on a tick with sec_left=0 and demand, where demand = car_ew OR ped_pending; otherwise it holds with sec_left=0.
REQ-020 Lamp outputs are a registered decode of state with no added latency: NS_GREEN ns=G ew=R; NS_YELLOW ns=Y ew=R; ALLRED_A/ALLRED_B both R; EW_GREEN ns=R ew=G; EW_YELLOW ns=R ew=Y.
REQ-021 ns_light and ew_light SHALL never both be non-red in the same cycle.
REQ-022 A state change SHALL occur only on a cycle with tick=1; the latency from a qualifying tick to the new lamp value is exactly one clk_in edge.
REQ-023 car_ew deasserting before sec_left reaches 0 SHALL cancel vehicle demand; it is not latched.

Reset
REQ-024 While reset=0, all state SHALL be forced immediately, independent of clk_in: state=NS_GREEN, sec_left=NS_GREEN_MIN-1, ns_light=G, ew_light=R, walk=0, ped_pending=0.
REQ-025 Assertion of reset in any state, including mid-yellow, SHALL abort the cycle; after reset releases, operation resumes from NS_GREEN with the full minimum green.

Configuration
REQ-026 With macro PED_WALK_EN defined, ped_req SHALL set an internal ped_pending latch in every state.
REQ-027 With PED_WALK_EN defined, ped_pending SHALL clear on entry to EW_GREEN; if ped_req arrives on that same edge, the clear SHALL win.
REQ-028 With PED_WALK_EN defined, walk SHALL equal 1 exactly while state=EW_GREEN and that green was entered with ped_pending=1.
REQ-029 With PED_WALK_EN undefined, ped_req SHALL be ignored, ped_pending SHALL be constant 0, and walk SHALL be constant 0.

Verification (NS_GREEN_MIN=4, YELLOW_TIME=2, ALLRED_TIME=1, EW_GREEN_TIME=3, tick every 5 clk_in cycles)
REQ-030 Reset, then 20 ticks with car_ew=0 -> state stays 0, sec_left goes 3,2,1,0 and then holds at 0, ns_light=G.
REQ-031 car_ew held 1 from reset -> states 0,1,2,3,4,5,0 lasting 4,2,1,3,2,1 ticks; REQ-021 checked on every cycle.
REQ-032 PED_WALK_EN defined, one ped_req pulse at tick 1, car_ew=0 -> NS_YELLOW after tick 4; walk=1 for exactly the 3 ticks of EW_GREEN; ped_pending=0 afterward.
REQ-033 PED_WALK_EN defined, ped_req on the same edge as entry to EW_GREEN -> ped_pending=0 and no second cycle is requested.
REQ-034 reset pulsed low for 2 cycles while state=1 with sec_left=1 -> state=0, sec_left=3, and ns_light=G immediately; the next transition needs 4 ticks.
REQ-035 PED_WALK_EN undefined, ped_req pulsed repeatedly, car_ew=0 -> state stays 0 and walk stays 0.
